ex_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the ID/EX and EX/MEM latches. Generates per-latch enable and flush strobes from three events:
- load-use hazards
- branch resolution (branch mask plus ALU condition flags)
- multi-cycle ALU operations

Sits beside the execution stage and drives the enable/clear inputs of the IF/ID, ID/EX and EX/MEM latches.

---
 rtl/ex_pipe_pkg.sv | 24 ++
 rtl/ex_hazard_detect.sv | 40 ++++
 rtl/ex_pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ex_pipe_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ex_pipe_pkg
// Shared types and constants for the execution-stage pipeline controller.
//   state_e      : controller states (RUN / LU_STALL / MULTI / FLUSH)
//   BR_ALWAYS    : branch-mask value meaning "unconditional"
//   FLAG_*       : bit positions of the {N,Z,C,V} ALU condition flags
// ---------------------------------------------------------------------------
package ex_pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MULTI    = 2'd2,
      ST_FLUSH    = 2'd3
   } state_e;

   localparam logic [3:0] BR_ALWAYS = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/ex_hazard_detect.sv
// ---------------------------------------------------------------------------
// ex_hazard_detect
// Combinational event decode for the pipeline controller.
// Ports:
//   ex_valid, ex_is_load, ex_rd   : instruction currently in EX
//   id_valid, id_rs1, id_rs2      : instruction currently in ID
//   ex_br, alu_cond               : branch mask and {N,Z,C,V} flags of EX
//   taken                         : EX branch resolves taken
//   lu_haz                        : ID reads the register an EX load writes
// ---------------------------------------------------------------------------
module ex_hazard_detect #(
   parameter int         REG_W     = 6,
   parameter logic [3:0] BR_ALWAYS = ex_pipe_pkg::BR_ALWAYS
) (
   input  logic             ex_valid,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic [3:0]       ex_br,
   input  logic [3:0]       alu_cond,
   output logic             taken,
   output logic             lu_haz
);

   // A non-zero mask is a branch; it is taken when unconditional or when any
   // selected flag is set.
   always_comb begin
      taken = ex_valid & (ex_br != 4'b0000) &
              ((ex_br == BR_ALWAYS) | (|(ex_br & alu_cond)));
   end

   // Register 0 is hard-wired, so a load targeting it never creates a hazard.
   always_comb begin
      lu_haz = ex_valid & ex_is_load & id_valid & (ex_rd != '0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   end

endmodule

// File: rtl/ex_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// ex_pipe_ctrl
// Sequencing controller for the IF/ID, ID/EX and EX/MEM latches. Turns
// load-use hazards, taken branches and multi-cycle ALU ops into latch
// enables and flush strobes.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   id_rs1, id_rs2, id_valid      : ID-stage operands
//   ex_rd, ex_is_load, ex_valid,
//   ex_multi, ex_br, alu_cond     : EX-stage instruction attributes
//   if_id_en, id_ex_en, ex_mem_en : latch load enables
//   if_id_flush, id_ex_flush      : latch clears (bubble insert)
//   br_taken                      : PC selects branch target (1-cycle pulse)
//   busy                          : controller is not in RUN
// Optional build macro EX_PIPE_CTRL_PERF_EN adds saturating counters:
//   stall_cnt                     : cycles with any enable low
//   flush_cnt                     : taken branches
// ---------------------------------------------------------------------------
module ex_pipe_ctrl #(
   parameter int         REG_W     = 6,
   parameter int         MULTI_CYC = 4,
   parameter logic [3:0] BR_ALWAYS = ex_pipe_pkg::BR_ALWAYS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_valid,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_valid,
   input  logic             ex_multi,
   input  logic [3:0]       ex_br,
   input  logic [3:0]       alu_cond,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             br_taken,
   output logic             busy
`ifdef EX_PIPE_CTRL_PERF_EN
   ,
   output logic [15:0]      stall_cnt,
   output logic [15:0]      flush_cnt
`endif
);

   import ex_pipe_pkg::*;

   // The RUN cycle that accepts the op is the first of the MULTI_CYC cycles,
   // and the counter==0 cycle in MULTI is the last, hence the -2.
   localparam logic [3:0] CNT_LOAD = 4'(MULTI_CYC - 2);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       taken;
   logic       luHaz;
   logic       multiGo;

   ex_hazard_detect #(
      .REG_W     (REG_W),
      .BR_ALWAYS (BR_ALWAYS)
   ) u_hazard (
      .ex_valid   (ex_valid),
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .id_valid   (id_valid),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .ex_br      (ex_br),
      .alu_cond   (alu_cond),
      .taken      (taken),
      .lu_haz     (luHaz)
   );

   assign multiGo = ex_multi & ex_valid;

   // State and multi-cycle counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and strobe decode. Outputs are also held at their idle values
   // while rst_n is low so that live inputs cannot leak through during reset.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      br_taken    = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_RUN: begin
               if (taken) begin
                  br_taken    = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  state_d     = ST_FLUSH;
               end else if (multiGo) begin
                  if_id_en  = 1'b0;
                  id_ex_en  = 1'b0;
                  ex_mem_en = 1'b0;
                  cnt_d     = CNT_LOAD;
                  state_d   = ST_MULTI;
               end else if (luHaz) begin
                  if_id_en    = 1'b0;
                  id_ex_en    = 1'b0;
                  id_ex_flush = 1'b1;
                  state_d     = ST_LU_STALL;
               end
            end
            ST_LU_STALL: state_d = ST_RUN;
            ST_FLUSH:    state_d = ST_RUN;
            ST_MULTI: begin
               if (cnt_q == 4'd0) begin
                  state_d = ST_RUN;
               end else begin
                  if_id_en  = 1'b0;
                  id_ex_en  = 1'b0;
                  ex_mem_en = 1'b0;
                  cnt_d     = cnt_q - 4'd1;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   assign busy = (state_q != ST_RUN);

`ifdef EX_PIPE_CTRL_PERF_EN
   logic [15:0] stallCnt_q;
   logic [15:0] flushCnt_q;

   // Saturating performance counters: stalled cycles and taken branches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt_q <= 16'd0;
         flushCnt_q <= 16'd0;
      end else begin
         if (!(if_id_en & id_ex_en & ex_mem_en) && (stallCnt_q != 16'hFFFF))
            stallCnt_q <= stallCnt_q + 16'd1;
         if (br_taken && (flushCnt_q != 16'hFFFF))
            flushCnt_q <= flushCnt_q + 16'd1;
      end
   end

   assign stall_cnt = stallCnt_q;
   assign flush_cnt = flushCnt_q;
`endif

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_pipe_ctrl
// Directed testbench for ex_pipe_ctrl. Output vector compared each step:
//   {if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, br_taken, busy}
// ---------------------------------------------------------------------------
module tb_ex_pipe_ctrl;

   localparam int REG_W = 6;

   // Expected output vectors, hand-derived from the controller behaviour.
   localparam logic [6:0] V_IDLE   = 7'b111_00_0_0;
   localparam logic [6:0] V_LU     = 7'b001_01_0_0;
   localparam logic [6:0] V_BR     = 7'b111_11_1_0;
   localparam logic [6:0] V_DRAIN  = 7'b111_00_0_1;
   localparam logic [6:0] V_MSTART = 7'b000_00_0_0;
   localparam logic [6:0] V_MBUSY  = 7'b000_00_0_1;

   logic             clk;
   logic             rst_n;
   logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
   logic             id_valid, ex_is_load, ex_valid, ex_multi;
   logic [3:0]       ex_br, alu_cond;
   logic             if_id_en, id_ex_en, ex_mem_en;
   logic             if_id_flush, id_ex_flush, br_taken, busy;
`ifdef EX_PIPE_CTRL_PERF_EN
   logic [15:0]      stall_cnt, flush_cnt;
`endif
   logic [6:0]       obs;

   int vecCount  = 0;
   int missCount = 0;

   ex_pipe_ctrl #(.REG_W(REG_W), .MULTI_CYC(4), .BR_ALWAYS(4'b1111)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_valid    (id_valid),
      .ex_rd       (ex_rd),
      .ex_is_load  (ex_is_load),
      .ex_valid    (ex_valid),
      .ex_multi    (ex_multi),
      .ex_br       (ex_br),
      .alu_cond    (alu_cond),
      .if_id_en    (if_id_en),
      .id_ex_en    (id_ex_en),
      .ex_mem_en   (ex_mem_en),
      .if_id_flush (if_id_flush),
      .id_ex_flush (id_ex_flush),
      .br_taken    (br_taken),
      .busy        (busy)
`ifdef EX_PIPE_CTRL_PERF_EN
      ,
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   assign obs = {if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, br_taken, busy};

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive every input to a quiet, no-event value.
   task automatic applyIdleStimulus();
      id_rs1     = '0;
      id_rs2     = '0;
      id_valid   = 1'b0;
      ex_rd      = '0;
      ex_is_load = 1'b0;
      ex_valid   = 1'b0;
      ex_multi   = 1'b0;
      ex_br      = 4'b0000;
      alu_cond   = 4'b0000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      applyIdleStimulus();
      #1;
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL reset_idle: got %b want %b", obs, V_IDLE);
      end
      // Live branch inputs must not show through while reset is held.
      ex_valid = 1'b1; ex_br = 4'b1111;
      #1;
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL reset_gated: got %b want %b", obs, V_IDLE);
      end
      applyIdleStimulus();
      #3 rst_n = 1'b1;
      tick();
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL reset_release: got %b want %b", obs, V_IDLE);
      end
   endtask

   task automatic test_load_use();
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 6'd5;
      id_valid = 1'b1; id_rs1 = 6'd3; id_rs2 = 6'd5;
      #1;
      vecCount++;
      if (obs !== V_LU) begin
         missCount++; $display("[TB] FAIL lu_stall: got %b want %b", obs, V_LU);
      end
      tick(); applyIdleStimulus(); #1;
      vecCount++;
      if (obs !== V_DRAIN) begin
         missCount++; $display("[TB] FAIL lu_state: got %b want %b", obs, V_DRAIN);
      end
      tick();
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL lu_return: got %b want %b", obs, V_IDLE);
      end
   endtask

   task automatic test_branch();
      ex_valid = 1'b1; ex_br = 4'b0100; alu_cond = 4'b0100;
      #1;
      vecCount++;
      if (obs !== V_BR) begin
         missCount++; $display("[TB] FAIL br_taken_z: got %b want %b", obs, V_BR);
      end
      tick(); applyIdleStimulus(); #1;
      vecCount++;
      if (obs !== V_DRAIN) begin
         missCount++; $display("[TB] FAIL br_flush_state: got %b want %b", obs, V_DRAIN);
      end
      tick();
      ex_valid = 1'b1; ex_br = 4'b0100; alu_cond = 4'b0000;
      #1;
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL br_not_taken: got %b want %b", obs, V_IDLE);
      end
      tick(); applyIdleStimulus(); #1;
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL br_not_taken_next: got %b want %b", obs, V_IDLE);
      end
   endtask

   // Starts a multi-cycle op in the current RUN cycle and walks it to the end.
   task automatic test_multi();
      logic [6:0] expSeq [4];
      expSeq[0] = V_MBUSY;
      expSeq[1] = V_MBUSY;
      expSeq[2] = V_DRAIN;
      expSeq[3] = V_IDLE;
      ex_valid = 1'b1; ex_multi = 1'b1;
      #1;
      vecCount++;
      if (obs !== V_MSTART) begin
         missCount++; $display("[TB] FAIL multi_start: got %b want %b", obs, V_MSTART);
      end
      for (int i = 0; i < 4; i++) begin
         tick(); applyIdleStimulus(); #1;
         vecCount++;
         if (obs !== expSeq[i]) begin
            missCount++; $display("[TB] FAIL multi_step%0d: got %b want %b", i, obs, expSeq[i]);
         end
      end
   endtask

`ifdef EX_PIPE_CTRL_PERF_EN
   task automatic test_perf();
      vecCount++;
      if (stall_cnt !== 16'd4) begin
         missCount++; $display("[TB] FAIL perf_stall: got %0d want 4", stall_cnt);
      end
      vecCount++;
      if (flush_cnt !== 16'd1) begin
         missCount++; $display("[TB] FAIL perf_flush: got %0d want 1", flush_cnt);
      end
   endtask
`endif

   task automatic test_reg_zero();
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 6'd0;
      id_valid = 1'b1; id_rs1 = 6'd0; id_rs2 = 6'd7;
      #1;
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL reg_zero: got %b want %b", obs, V_IDLE);
      end
      // Same match but ID slot empty: no hazard either.
      ex_rd = 6'd7; id_valid = 1'b0;
      #1;
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL id_invalid: got %b want %b", obs, V_IDLE);
      end
      tick(); applyIdleStimulus();
   endtask

   task automatic test_priority();
      ex_valid = 1'b1; ex_br = 4'b0100; alu_cond = 4'b0100; ex_multi = 1'b1;
      ex_is_load = 1'b1; ex_rd = 6'd5; id_valid = 1'b1; id_rs1 = 6'd5;
      #1;
      vecCount++;
      if (obs !== V_BR) begin
         missCount++; $display("[TB] FAIL prio_branch: got %b want %b", obs, V_BR);
      end
      tick(); applyIdleStimulus(); tick();
      // Multi beats load-use: EX/MEM held, no bubble.
      ex_valid = 1'b1; ex_multi = 1'b1; ex_is_load = 1'b1;
      ex_rd = 6'd9; id_valid = 1'b1; id_rs2 = 6'd9;
      #1;
      vecCount++;
      if (obs !== V_MSTART) begin
         missCount++; $display("[TB] FAIL prio_multi: got %b want %b", obs, V_MSTART);
      end
      tick(); applyIdleStimulus();
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_branch_edges();
      ex_valid = 1'b1; ex_br = 4'b1111; alu_cond = 4'b0000;
      #1;
      vecCount++;
      if (obs !== V_BR) begin
         missCount++; $display("[TB] FAIL br_always: got %b want %b", obs, V_BR);
      end
      // Taken condition held into FLUSH must be ignored.
      tick(); #1;
      vecCount++;
      if (obs !== V_DRAIN) begin
         missCount++; $display("[TB] FAIL br_in_flush: got %b want %b", obs, V_DRAIN);
      end
      tick(); applyIdleStimulus();
      ex_valid = 1'b0; ex_br = 4'b1111;
      #1;
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL br_ex_invalid: got %b want %b", obs, V_IDLE);
      end
      ex_valid = 1'b1; ex_br = 4'b0011; alu_cond = 4'b1100;
      #1;
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL br_mask_miss: got %b want %b", obs, V_IDLE);
      end
      tick(); applyIdleStimulus();
   endtask

   task automatic test_reset_mid_multi();
      ex_valid = 1'b1; ex_multi = 1'b1;
      tick(); applyIdleStimulus(); tick();
      #1;
      vecCount++;
      if (obs !== V_MBUSY) begin
         missCount++; $display("[TB] FAIL rst_pre_multi: got %b want %b", obs, V_MBUSY);
      end
      rst_n = 1'b0;
      #1;
      vecCount++;
      if (obs !== V_IDLE) begin
         missCount++; $display("[TB] FAIL rst_async: got %b want %b", obs, V_IDLE);
      end
      #2 rst_n = 1'b1;
      tick();
      test_multi();
   endtask

   task automatic test_back_to_back();
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 6'd12;
      id_valid = 1'b1; id_rs1 = 6'd12; id_rs2 = 6'd1;
      #1;
      vecCount++;
      if (obs !== V_LU) begin
         missCount++; $display("[TB] FAIL b2b_first: got %b want %b", obs, V_LU);
      end
      tick(); #1;
      vecCount++;
      if (obs !== V_DRAIN) begin
         missCount++; $display("[TB] FAIL b2b_hold: got %b want %b", obs, V_DRAIN);
      end
      tick(); #1;
      vecCount++;
      if (obs !== V_LU) begin
         missCount++; $display("[TB] FAIL b2b_second: got %b want %b", obs, V_LU);
      end
      tick(); applyIdleStimulus(); tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_multi();
`ifdef EX_PIPE_CTRL_PERF_EN
      test_perf();
`endif
      test_reg_zero();
      test_priority();
      test_branch_edges();
      test_reset_mid_multi();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
